// File: rtl/cmul_rr_arbiter.sv
// Round-robin arbiter that shares one external complex multiplier between NUM_REQ requesters.
// Two-stage elastic pipeline: operand registers feed the cmul, result registers capture its output.

module cmul_rr_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX     = 0,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [ID_W-1:0]    i_ptr,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic               o_grant
);
  logic [ID_W:0] w_pos;
  logic          w_seen;
  logic          w_blocked;

  // Walk from i_ptr+1; this lane wins if it is valid and nobody earlier in the walk is.
  always_comb begin
    w_pos     = '0;
    w_seen    = 1'b0;
    w_blocked = 1'b0;
    o_grant   = 1'b0;
    for (int d = 1; d <= NUM_REQ; d++) begin
      w_pos = {1'b0, i_ptr} + (ID_W+1)'(d);
      if (w_pos >= (ID_W+1)'(NUM_REQ)) w_pos = w_pos - (ID_W+1)'(NUM_REQ);
      if (!w_seen) begin
        if (w_pos[ID_W-1:0] == ID_W'(IDX)) begin
          w_seen  = 1'b1;
          o_grant = i_valid[IDX] & ~w_blocked;
        end else begin
          w_blocked = w_blocked | i_valid[w_pos[ID_W-1:0]];
        end
      end
    end
  end
endmodule

module cmul_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_imag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_imag,
  output logic [DATA_WIDTH-1:0]         mul_a_real,
  output logic [DATA_WIDTH-1:0]         mul_a_imag,
  output logic [DATA_WIDTH-1:0]         mul_b_real,
  output logic [DATA_WIDTH-1:0]         mul_b_imag,
  input  logic [DATA_WIDTH-1:0]         mul_y_real,
  input  logic [DATA_WIDTH-1:0]         mul_y_imag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_y_real,
  output logic [DATA_WIDTH-1:0]         rsp_y_imag
);
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_ar, w_ai, w_br, w_bi;
  logic [NUM_REQ-1:0]                 w_grant;
  logic [ID_W-1:0]                    w_gid;
  logic                               w_rsp_can, w_op_can, w_accept;

  logic                  r_op_valid;
  logic [ID_W-1:0]       r_op_id;
  logic [ID_W-1:0]       r_ptr;
  logic [DATA_WIDTH-1:0] r_mul_ar, r_mul_ai, r_mul_br, r_mul_bi;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_yr, r_rsp_yi;

  assign w_ar = req_a_real;
  assign w_ai = req_a_imag;
  assign w_br = req_b_real;
  assign w_bi = req_b_imag;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    cmul_rr_lane #(.NUM_REQ(NUM_REQ), .IDX(g)) u_lane (
      .i_ptr   (r_ptr),
      .i_valid (req_valid),
      .o_grant (w_grant[g])
    );
  end

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) w_gid = ID_W'(i);
  end

  assign w_rsp_can = ~r_rsp_valid | rsp_ready;
  assign w_op_can  = ~r_op_valid | w_rsp_can;
  // Held low during reset so nothing is handed a ready while state is being cleared.
  assign req_ready = (w_op_can && !rst) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_valid  <= 1'b0;
      r_op_id     <= '0;
      r_ptr       <= ID_W'(NUM_REQ-1);
      r_mul_ar    <= '0;
      r_mul_ai    <= '0;
      r_mul_br    <= '0;
      r_mul_bi    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_yr    <= '0;
      r_rsp_yi    <= '0;
    end else begin
      if (w_rsp_can) begin
        r_rsp_valid <= r_op_valid;
        if (r_op_valid) begin
          r_rsp_id <= r_op_id;
          r_rsp_yr <= mul_y_real;
          r_rsp_yi <= mul_y_imag;
        end
      end
      // mul_* only move on an accept so the cmul inputs stay quiet when idle.
      if (w_op_can) begin
        r_op_valid <= w_accept;
        if (w_accept) begin
          r_op_id  <= w_gid;
          r_ptr    <= w_gid;
          r_mul_ar <= w_ar[w_gid];
          r_mul_ai <= w_ai[w_gid];
          r_mul_br <= w_br[w_gid];
          r_mul_bi <= w_bi[w_gid];
        end
      end
    end
  end

  assign mul_a_real = r_mul_ar;
  assign mul_a_imag = r_mul_ai;
  assign mul_b_real = r_mul_br;
  assign mul_b_imag = r_mul_bi;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_y_real = r_rsp_yr;
  assign rsp_y_imag = r_rsp_yi;
endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// Bench for cmul_rr_arbiter: saturating cmul stand-in, transaction-level model checked every
// negedge, and directed scenarios with hand-computed expectations.
module tb_cmul_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_a_real, req_a_imag, req_b_real, req_b_imag;
  logic [DW-1:0]    mul_a_real, mul_a_imag, mul_b_real, mul_b_imag;
  logic [DW-1:0]    mul_y_real, mul_y_imag;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_y_real, rsp_y_imag;

  int n_chk = 0;
  int n_err = 0;
  int acc_log[$];
  int rsp_log[$];
  int exp34[6] = '{0, 1, 2, 3, 0, 1};
  int exp38[4] = '{1, 3, 1, 3};

  always #5 clk = ~clk;

  cmul_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_real(req_a_real), .req_a_imag(req_a_imag),
    .req_b_real(req_b_real), .req_b_imag(req_b_imag),
    .mul_a_real(mul_a_real), .mul_a_imag(mul_a_imag),
    .mul_b_real(mul_b_real), .mul_b_imag(mul_b_imag),
    .mul_y_real(mul_y_real), .mul_y_imag(mul_y_imag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y_real(rsp_y_real), .rsp_y_imag(rsp_y_imag)
  );

  function automatic int sx(logic [DW-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [DW-1:0] sat(int v);
    if (v > 127)  return 8'd127;
    if (v < -127) return 8'h81;
    return v[DW-1:0];
  endfunction

  // Stand-in for the external cmul: full complex product, symmetric saturation.
  assign mul_y_real = sat(sx(mul_a_real)*sx(mul_b_real) - sx(mul_a_imag)*sx(mul_b_imag));
  assign mul_y_imag = sat(sx(mul_a_real)*sx(mul_b_imag) + sx(mul_a_imag)*sx(mul_b_real));

  function automatic int rr_pick(int ptr, logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(ptr+k)%NR]) return (ptr+k)%NR;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a last-winner pointer plus two occupancy slots, one per pipeline stage.
  int            m_ptr, m_op_id, m_rsp_id;
  bit            m_op_v, m_rsp_v;
  logic [DW-1:0] m_ar, m_ai, m_br, m_bi, m_yr, m_yi;

  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    bit rsp_can, op_can;
    int g, id;
    exp_rdy = '0; rsp_can = 1'b0; op_can = 1'b0; g = -1;
    if (rst) begin
      m_ptr = NR-1; m_op_v = 0; m_rsp_v = 0; m_op_id = 0; m_rsp_id = 0;
      m_ar = 0; m_ai = 0; m_br = 0; m_bi = 0; m_yr = 0; m_yi = 0;
    end else begin
      rsp_can = !m_rsp_v || rsp_ready;
      op_can  = !m_op_v || rsp_can;
      g = rr_pick(m_ptr, req_valid);
      if (op_can && g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready",  32'(req_ready),  32'(exp_rdy));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_rsp_v));
    chk("rsp_id",     32'(rsp_id),     32'(m_rsp_id));
    chk("rsp_y_real", 32'(rsp_y_real), 32'(m_yr));
    chk("rsp_y_imag", 32'(rsp_y_imag), 32'(m_yi));
    chk("mul_a_real", 32'(mul_a_real), 32'(m_ar));
    chk("mul_a_imag", 32'(mul_a_imag), 32'(m_ai));
    chk("mul_b_real", 32'(mul_b_real), 32'(m_br));
    chk("mul_b_imag", 32'(mul_b_imag), 32'(m_bi));
    if (!rst) begin
      id = -1;
      for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) id = i;
      if (id >= 0) acc_log.push_back(id);
      if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
      if (rsp_can) begin
        m_rsp_v = m_op_v;
        if (m_op_v) begin
          m_rsp_id = m_op_id;
          m_yr = sat(sx(m_ar)*sx(m_br) - sx(m_ai)*sx(m_bi));
          m_yi = sat(sx(m_ar)*sx(m_bi) + sx(m_ai)*sx(m_br));
        end
      end
      if (op_can) begin
        m_op_v = (g >= 0);
        if (g >= 0) begin
          m_op_id = g; m_ptr = g;
          m_ar = req_a_real[g*DW +: DW]; m_ai = req_a_imag[g*DW +: DW];
          m_br = req_b_real[g*DW +: DW]; m_bi = req_b_imag[g*DW +: DW];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input int ar, input int ai, input int br, input int bi);
    req_a_real[i*DW +: DW] = ar[DW-1:0];
    req_a_imag[i*DW +: DW] = ai[DW-1:0];
    req_b_real[i*DW +: DW] = br[DW-1:0];
    req_b_imag[i*DW +: DW] = bi[DW-1:0];
  endtask

  task automatic rst_pulse();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    req_a_real = '0; req_a_imag = '0; req_b_real = '0; req_b_imag = '0;
    repeat (3) tick();

    // Single request from 2, accepted on the first edge after reset release.
    set_req(2, 3, 2, 4, -1);
    req_valid = 4'b0100; rst = 1'b0;
    tick();
    req_valid = '0;
    tick();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id",    32'(rsp_id),    32'd2);
    chk("single_yr",    32'(rsp_y_real), 32'd14);
    chk("single_yi",    32'(rsp_y_imag), 32'd5);
    tick();

    // All four requesters continuously valid, then backpressure.
    rst_pulse();
    set_req(0, 1, 2, 3, 4); set_req(1, -5, 6, 7, -8);
    set_req(2, 10, -3, -2, 9); set_req(3, 20, 20, 5, -5);
    acc_log.delete(); rsp_log.delete();
    req_valid = 4'b1111;
    repeat (6) tick();
    chk("rr_count", 32'(acc_log.size() >= 6), 32'd1);
    for (int j = 0; j < 6; j++) chk($sformatf("rr_order%0d", j), 32'(acc_log[j]), 32'(exp34[j]));

    rsp_ready = 1'b0;
    n0 = acc_log.size();
    repeat (5) tick();
    chk("bp_accepts_le2", 32'((acc_log.size() - n0) <= 2), 32'd1);
    rsp_ready = 1'b1;
    repeat (8) tick();
    req_valid = '0;
    repeat (4) tick();
    for (int j = 0; j + 1 < acc_log.size(); j++)
      chk($sformatf("bp_rr%0d", j), 32'(acc_log[j+1]), 32'((acc_log[j] + 1) % NR));
    chk("bp_rsp_count", 32'(rsp_log.size()), 32'(acc_log.size()));
    for (int j = 0; j < acc_log.size() && j < rsp_log.size(); j++)
      chk($sformatf("bp_rsp%0d", j), 32'(rsp_log[j]), 32'(acc_log[j]));

    // Saturated results pass straight through.
    set_req(0, 127, 0, 127, 0);
    req_valid = 4'b0001; tick(); req_valid = '0; tick();
    chk("sat_pos_valid", 32'(rsp_valid), 32'd1);
    chk("sat_pos_yr",    32'(rsp_y_real), 32'd127);
    chk("sat_pos_yi",    32'(rsp_y_imag), 32'd0);
    set_req(0, 0, 100, 0, 100);
    req_valid = 4'b0001; tick(); req_valid = '0; tick();
    chk("sat_neg_yr", 32'(rsp_y_real), 32'h81);
    chk("sat_neg_yi", 32'(rsp_y_imag), 32'd0);
    tick();

    // Reset while both stages hold data.
    req_valid = 4'b1111; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1; #2;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    chk("async_mul_ar",    32'(mul_a_real), 32'd0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1; acc_log.delete();
    tick();
    chk("post_rst_first", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd0);
    chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    repeat (3) tick();

    // Sparse requesters 1 and 3 only.
    rst_pulse();
    acc_log.delete();
    req_valid = 4'b1010;
    repeat (4) tick();
    chk("sparse_count", 32'(acc_log.size()), 32'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("sparse%0d", j), 32'(acc_log[j]), 32'(exp38[j]));
    req_valid = '0;
    repeat (3) tick();

    // Mixed traffic: random valids, backpressure and operand churn.
    for (int c = 0; c < 40; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++)
        set_req(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
